// File: rtl/loop_nest_sched.sv
// Two-level (i,j) loop-nest sequencer for a shared MAC datapath: issues index pairs with a
// bounded number in flight and accumulates in-order responses weighted by (j+1).
module loop_nest_sched #(
  parameter int N       = 8,
  parameter int IDX_W   = $clog2(N),
  parameter int DATA_W  = 16,
  parameter int ACC_W   = 40,
  parameter int MAX_OUT = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  input  logic                     abort_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     aborted_o,
  output logic                     issue_valid_o,
  input  logic                     issue_ready_i,
  output logic [IDX_W-1:0]         issue_i_o,
  output logic [IDX_W-1:0]         issue_j_o,
  output logic                     issue_last_o,
  input  logic                     rsp_valid_i,
  input  logic [DATA_W-1:0]        rsp_data_i,
  output logic [ACC_W-1:0]         acc_o
);

  // state  | meaning
  // IDLE   | waiting for start_i
  // ISSUE  | handing out (i,j) pairs, bounded by MAX_OUT in flight
  // DRAIN  | no new requests, waiting for outstanding responses
  // DONE   | one-cycle completion pulse
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  localparam int CNT_W  = $clog2(MAX_OUT + 1);
  localparam int PROD_W = IDX_W + 1 + DATA_W;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
  localparam logic [CNT_W-1:0] OUT_MAX  = CNT_W'(MAX_OUT);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   i_q, i_d, j_q, j_d, rj_q, rj_d;
  logic [CNT_W-1:0]   out_q, out_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               abort_seen_q, abort_seen_d;
  logic               aborted_q, aborted_d;
  logic               issue_valid, hs, rsp_acc;
  logic [PROD_W-1:0]  data_x, weight_x, prod;

  // Weight (rj+1) can equal N, so it is zero-extended before the signed multiply.
  assign data_x   = {{(PROD_W-DATA_W){rsp_data_i[DATA_W-1]}}, rsp_data_i};
  assign weight_x = PROD_W'(rj_q) + PROD_W'(1);
  assign prod     = PROD_W'($signed(data_x) * $signed(weight_x));

  assign issue_valid = (state_q == S_ISSUE) && (out_q < OUT_MAX) && !abort_seen_q;
  assign hs          = issue_valid && issue_ready_i;
  assign rsp_acc     = rsp_valid_i && (out_q != '0);

  always_comb begin
    state_d      = state_q;
    i_d          = i_q;
    j_d          = j_q;
    rj_d         = rj_q;
    out_d        = out_q;
    acc_d        = acc_q;
    abort_seen_d = abort_seen_q;
    aborted_d    = aborted_q;

    if (hs && !rsp_acc)      out_d = out_q + CNT_W'(1);
    else if (!hs && rsp_acc) out_d = out_q - CNT_W'(1);

    if (rsp_acc) begin
      acc_d = acc_q + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
      rj_d  = (rj_q == IDX_LAST) ? '0 : rj_q + IDX_W'(1);
    end

    if (hs) begin
      if (j_q == IDX_LAST) begin
        j_d = '0;
        i_d = (i_q == IDX_LAST) ? '0 : i_q + IDX_W'(1);
      end else begin
        j_d = j_q + IDX_W'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d      = S_ISSUE;
          i_d          = '0;
          j_d          = '0;
          rj_d         = '0;
          out_d        = '0;
          acc_d        = '0;
          abort_seen_d = 1'b0;
          aborted_d    = 1'b0;
        end
      end
      S_ISSUE: begin
        if (abort_i) begin
          abort_seen_d = 1'b1;
          state_d      = S_DRAIN;
        end
        if (hs && (i_q == IDX_LAST) && (j_q == IDX_LAST)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (out_q == '0) begin
          state_d   = S_DONE;
          aborted_d = abort_seen_q;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      i_q          <= '0;
      j_q          <= '0;
      rj_q         <= '0;
      out_q        <= '0;
      acc_q        <= '0;
      abort_seen_q <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      i_q          <= i_d;
      j_q          <= j_d;
      rj_q         <= rj_d;
      out_q        <= out_d;
      acc_q        <= acc_d;
      abort_seen_q <= abort_seen_d;
      aborted_q    <= aborted_d;
    end
  end

  assign busy_o        = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign done_o        = (state_q == S_DONE);
  assign aborted_o     = aborted_q;
  assign issue_valid_o = issue_valid;
  assign issue_i_o     = i_q;
  assign issue_j_o     = j_q;
  assign issue_last_o  = issue_valid && (i_q == IDX_LAST) && (j_q == IDX_LAST);
  assign acc_o         = acc_q;

endmodule

// File: tb/tb_loop_nest_sched.sv
// Bench for loop_nest_sched: table of whole-pass vectors plus hand-written abort, cap,
// reset and stray-input sequences; issue order and responses tracked through queues.
module tb_loop_nest_sched;
  localparam int N = 4, IDX_W = 2, DATA_W = 16, ACC_W = 40, MAX_OUT = 2;

  logic clk = 1'b0, rst_n = 1'b0, start_i = 1'b0, abort_i = 1'b0;
  logic issue_ready_i = 1'b0, rsp_valid_i = 1'b0;
  logic [DATA_W-1:0] rsp_data_i = '0;
  logic busy_o, done_o, aborted_o, issue_valid_o, issue_last_o;
  logic [IDX_W-1:0] issue_i_o, issue_j_o;
  logic [ACC_W-1:0] acc_o;

  always #5 clk = ~clk;

  loop_nest_sched #(.N(N), .IDX_W(IDX_W), .DATA_W(DATA_W), .ACC_W(ACC_W), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
    .busy_o(busy_o), .done_o(done_o), .aborted_o(aborted_o),
    .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
    .issue_i_o(issue_i_o), .issue_j_o(issue_j_o), .issue_last_o(issue_last_o),
    .rsp_valid_i(rsp_valid_i), .rsp_data_i(rsp_data_i), .acc_o(acc_o)
  );

  typedef struct {
    bit     tog;
    int     ready_lim;
    int     lat;
    int     data;
    bit     abort_en;
    longint exp_acc;
    bit     exp_ab;
    int     exp_hs;
  } vec_t;

  int checks = 0, failures = 0;
  int cyc = 0, hs_cnt, rsp_cnt, out_m, rj_m, done_cnt, done_cyc, last_rsp_cyc;
  int ready_lim, rsp_lat, rsp_allow, abort_hs, abort_rsp, data_const;
  bit tog, abort_en, abort_fired, in_issue, data_rand, start_noise, force_start, force_rsp;
  longint m_acc, done_acc;
  bit done_ab;
  int exp_q[$], pend[$], dq[$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: drive inputs at the falling edge, check outputs, update the model after the rising edge.
  task automatic cycle();
    bit hs, rv;
    hs = 1'b0;
    rv = 1'b0;
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc;
      done_acc = longint'($signed(acc_o));
      done_ab  = aborted_o;
    end
    start_i       = force_start || (start_noise && (done_o || (busy_o && (cyc % 5 == 0))));
    issue_ready_i = (hs_cnt < ready_lim) && (!tog || (cyc % 2 == 1));
    abort_i       = abort_en && !abort_fired && (hs_cnt >= abort_hs) && (rsp_cnt >= abort_rsp);
    rsp_valid_i   = 1'b0;
    rsp_data_i    = '0;
    if (force_rsp) begin
      rsp_valid_i = 1'b1;
      rsp_data_i  = 16'h04D2;
    end else if (rsp_allow > 0 && pend.size() > 0 && pend[0] <= cyc) begin
      rv          = 1'b1;
      rsp_valid_i = 1'b1;
      rsp_data_i  = DATA_W'(dq[0]);
    end
    chk("issue_valid", longint'(issue_valid_o), longint'(in_issue && (out_m < MAX_OUT)));
    if (issue_valid_o) begin
      if (exp_q.size() == 0) chk("issue_extra", 1, 0);
      else begin
        chk("issue_i", longint'(issue_i_o), longint'(exp_q[0] / N));
        chk("issue_j", longint'(issue_j_o), longint'(exp_q[0] % N));
        chk("issue_last", longint'(issue_last_o), longint'(exp_q[0] == N*N-1));
      end
    end
    hs = issue_valid_o && issue_ready_i;
    @(posedge clk);
    if (rv) begin
      m_acc += longint'(dq[0]) * longint'(rj_m + 1);
      rj_m = (rj_m + 1) % N;
      void'(pend.pop_front());
      void'(dq.pop_front());
      out_m--;
      rsp_cnt++;
      rsp_allow--;
      last_rsp_cyc = cyc;
    end
    if (hs && exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      pend.push_back(cyc + rsp_lat);
      dq.push_back(data_rand ? int'($urandom_range(0, 65535)) - 32768 : data_const);
      hs_cnt++;
      out_m++;
      if (exp_q.size() == 0) in_issue = 1'b0;
    end
    if (abort_i) begin
      abort_fired = 1'b1;
      in_issue    = 1'b0;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic start_pass();
    exp_q.delete();
    pend.delete();
    dq.delete();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) exp_q.push_back(i*N + j);
    m_acc = 0; rj_m = 0; out_m = 0; hs_cnt = 0; rsp_cnt = 0;
    abort_fired = 1'b0; done_cnt = 0; done_cyc = -1; last_rsp_cyc = -1; in_issue = 1'b0;
    force_start = 1'b1;
    cycle();
    force_start = 1'b0;
    in_issue = 1'b1;
  endtask

  task automatic run_to_done();
    for (int k = 0; k < 400 && done_cnt == 0; k++) cycle();
    if (done_cnt == 0) begin
      chk("done_timeout", 0, 1);
      return;
    end
    cycle();
    cycle();
    chk("done_once", longint'(done_cnt), 1);
    chk("done_latency", longint'(done_cyc - last_rsp_cyc), 2);
    chk("acc_model", done_acc, m_acc);
    chk("busy_after_done", longint'(busy_o), 0);
  endtask

  initial begin
    vec_t vecs[6];
    vecs[0] = '{tog: 1'b0, ready_lim: 1000, lat: 1, data: 5,      abort_en: 1'b0, exp_acc: 200,      exp_ab: 1'b0, exp_hs: 16};
    vecs[1] = '{tog: 1'b1, ready_lim: 1000, lat: 3, data: -3,     abort_en: 1'b0, exp_acc: -120,     exp_ab: 1'b0, exp_hs: 16};
    vecs[2] = '{tog: 1'b0, ready_lim: 1000, lat: 5, data: 32767,  abort_en: 1'b0, exp_acc: 1310680,  exp_ab: 1'b0, exp_hs: 16};
    vecs[3] = '{tog: 1'b1, ready_lim: 1000, lat: 1, data: -32768, abort_en: 1'b0, exp_acc: -1310720, exp_ab: 1'b0, exp_hs: 16};
    vecs[4] = '{tog: 1'b0, ready_lim: 3,    lat: 1, data: 7,      abort_en: 1'b1, exp_acc: 42,       exp_ab: 1'b1, exp_hs: 3};
    vecs[5] = '{tog: 1'b0, ready_lim: 3,    lat: 4, data: -100,   abort_en: 1'b1, exp_acc: -600,     exp_ab: 1'b1, exp_hs: 3};

    tog = 0; ready_lim = 1000; rsp_lat = 1; rsp_allow = 1000; abort_en = 0; abort_hs = 3; abort_rsp = 2;
    data_const = 0; data_rand = 0; start_noise = 0; force_start = 0; force_rsp = 0; in_issue = 0;
    out_m = 0; hs_cnt = 0; rsp_cnt = 0; done_cnt = 0; abort_fired = 0;

    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("reset_flags", longint'({busy_o, done_o, aborted_o, issue_valid_o, issue_last_o}), 0);
    chk("reset_idx", longint'({issue_i_o, issue_j_o}), 0);
    chk("reset_acc", longint'($signed(acc_o)), 0);
    rst_n = 1'b1;

    foreach (vecs[v]) begin
      tog = vecs[v].tog; ready_lim = vecs[v].ready_lim; rsp_lat = vecs[v].lat;
      data_const = vecs[v].data; abort_en = vecs[v].abort_en; abort_hs = 3; abort_rsp = 2;
      rsp_allow = 1000; data_rand = 0;
      start_pass();
      run_to_done();
      chk("acc", done_acc, vecs[v].exp_acc);
      chk("aborted", longint'(done_ab), longint'(vecs[v].exp_ab));
      chk("handshakes", longint'(hs_cnt), longint'(vecs[v].exp_hs));
      force_rsp = 1'b1;
      cycle();
      cycle();
      force_rsp = 1'b0;
      chk("acc_hold_idle_rsp", longint'($signed(acc_o)), vecs[v].exp_acc);
      chk("aborted_hold", longint'(aborted_o), longint'(vecs[v].exp_ab));
    end
    abort_en = 1'b0;

    // Random data with start_i pulsed while busy and during DONE.
    tog = 1'b1; ready_lim = 1000; rsp_lat = 2; rsp_allow = 1000; data_rand = 1'b1; start_noise = 1'b1;
    start_pass();
    run_to_done();
    start_noise = 1'b0;
    chk("noise_handshakes", longint'(hs_cnt), N*N);
    chk("noise_aborted", longint'(done_ab), 0);

    // Outstanding cap: no responses for 10 cycles, then release exactly one.
    tog = 1'b0; rsp_lat = 1; rsp_allow = 0;
    start_pass();
    repeat (10) cycle();
    chk("cap_handshakes", longint'(hs_cnt), MAX_OUT);
    chk("cap_valid_low", longint'(issue_valid_o), 0);
    rsp_allow = 1;
    repeat (5) cycle();
    chk("cap_one_more", longint'(hs_cnt), MAX_OUT + 1);
    rsp_allow = 1000;
    run_to_done();
    chk("cap_total", longint'(hs_cnt), N*N);

    // Reset in DRAIN with one request outstanding.
    ready_lim = 1; rsp_allow = 0; abort_en = 1'b1; abort_hs = 1; abort_rsp = 0;
    start_pass();
    repeat (4) cycle();
    chk("drain_busy", longint'(busy_o), 1);
    chk("drain_out", longint'(out_m), 1);
    rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0; issue_ready_i = 1'b0; rsp_valid_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    rst_n = 1'b1;
    chk("midreset_flags", longint'({busy_o, done_o, aborted_o, issue_valid_o, issue_last_o}), 0);
    chk("midreset_idx", longint'({issue_i_o, issue_j_o}), 0);
    chk("midreset_acc", longint'($signed(acc_o)), 0);
    pend.delete(); dq.delete(); in_issue = 1'b0; out_m = 0; abort_en = 1'b0; done_cnt = 0;
    force_rsp = 1'b1;
    cycle();
    force_rsp = 1'b0;
    cycle();
    cycle();
    chk("late_rsp_acc", longint'($signed(acc_o)), 0);
    chk("late_rsp_busy", longint'(busy_o), 0);
    chk("late_rsp_no_done", longint'(done_cnt), 0);
    ready_lim = 1000; rsp_allow = 1000; rsp_lat = 3; data_rand = 1'b1;
    start_pass();
    run_to_done();
    chk("post_reset_handshakes", longint'(hs_cnt), N*N);
    chk("post_reset_aborted", longint'(done_ab), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
